// File: rtl/core_types_pkg.sv
// Shared BTB geometry and entry types for the front-end predictor blocks.
// The hash field map (set index, tag) is fixed by these widths.
package core_types_pkg;

  localparam int BTB_TAG_WIDTH       = 6;
  localparam int BTB_SET_INDEX_WIDTH = 8;
  localparam int BTB_NUM_WAYS        = 2;
  localparam int BTB_TARGET_WIDTH    = 32;

  typedef struct packed {
    logic                        valid;
    logic [BTB_TAG_WIDTH-1:0]    tag;
    logic [BTB_TARGET_WIDTH-1:0] target;
  } btb_entry_t;

  typedef struct packed {
    btb_entry_t [BTB_NUM_WAYS-1:0] way;
    logic                          lru;
  } btb_set_t;

endpackage

// File: rtl/btb_tag_hash.sv
// Splits a (PC, ASID) pair into BTB set index and folded tag.
// Purely combinational; shared by the lookup and training paths.
module btb_tag_hash
  import core_types_pkg::*;
(
  input  logic [31:0]                    pc,
  input  logic [8:0]                     asid,
  output logic [BTB_SET_INDEX_WIDTH-1:0] set_idx,
  output logic [BTB_TAG_WIDTH-1:0]       tag
);

  assign set_idx = pc[11:4];
  assign tag     = pc[23:18] ^ pc[17:12] ^ asid[5:0];

  // High PC bits, fetch-block offset and upper ASID bits do not enter the hash.
  logic unused_hash_bits;
  assign unused_hash_bits = ^{pc[31:24], pc[3:0], asid[8:6]};

endmodule

// File: rtl/btb_tag_lookup.sv
// 2-way set-associative BTB: 1-cycle lookup pipeline plus training writes.
// Lookups read the array as it stood before any same-edge update or flush.
module btb_tag_lookup
  import core_types_pkg::*;
#(
  parameter int TARGET_WIDTH = BTB_TARGET_WIDTH,
  parameter int NUM_SETS     = 1 << BTB_SET_INDEX_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    valid_REQ,
  input  logic [31:0]             PC_REQ,
  input  logic [8:0]              ASID_REQ,
  output logic                    valid_RESP,
  output logic                    hit_RESP,
  output logic                    hit_way_RESP,
  output logic [TARGET_WIDTH-1:0] target_RESP,
  input  logic                    update_valid,
  input  logic [31:0]             update_PC,
  input  logic [8:0]              update_ASID,
  input  logic [TARGET_WIDTH-1:0] update_target,
  input  logic                    flush
);

  logic [BTB_NUM_WAYS-1:0]  valid_q  [NUM_SETS];
  logic                     lru_q    [NUM_SETS];
  logic [BTB_TAG_WIDTH-1:0] tag_q    [NUM_SETS][BTB_NUM_WAYS];
  logic [TARGET_WIDTH-1:0]  target_q [NUM_SETS][BTB_NUM_WAYS];

  logic [BTB_SET_INDEX_WIDTH-1:0] req_idx, up_idx, resp_idx_q;
  logic [BTB_TAG_WIDTH-1:0]       req_tag, up_tag, resp_tag_q;

  btb_tag_hash u_req_hash (.pc(PC_REQ),    .asid(ASID_REQ),    .set_idx(req_idx), .tag(req_tag));
  btb_tag_hash u_up_hash  (.pc(update_PC), .asid(update_ASID), .set_idx(up_idx),  .tag(up_tag));

  btb_set_t req_set, resp_set_q;
  logic     resp_valid_q, resp_flush_q;

  always_comb begin
    req_set = '0;
    for (int w = 0; w < BTB_NUM_WAYS; w++) begin
      req_set.way[w].valid  = valid_q[req_idx][w];
      req_set.way[w].tag    = tag_q[req_idx][w];
      req_set.way[w].target = target_q[req_idx][w];
    end
    req_set.lru = lru_q[req_idx];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid_q <= 1'b0;
      resp_flush_q <= 1'b0;
    end else begin
      resp_valid_q <= valid_REQ;
      resp_flush_q <= flush;
    end
  end

  // NOTE: payload registers carry no reset; resp_valid_q gates every output derived from them.
  always_ff @(posedge CLK) begin
    resp_set_q <= req_set;
    resp_tag_q <= req_tag;
    resp_idx_q <= req_idx;
  end

  logic unused_resp_lru;
  assign unused_resp_lru = resp_set_q.lru;

  logic [BTB_NUM_WAYS-1:0] way_match;
  logic                    lookup_hit, hit_way;

  always_comb begin
    way_match = '0;
    for (int w = 0; w < BTB_NUM_WAYS; w++)
      way_match[w] = resp_set_q.way[w].valid && (resp_set_q.way[w].tag == resp_tag_q);
  end

  // Way 0 wins a double match; a lookup that shared its cycle with a flush never hits.
  assign lookup_hit   = resp_valid_q && !resp_flush_q && (|way_match);
  assign hit_way      = lookup_hit && !way_match[0];
  assign valid_RESP   = resp_valid_q;
  assign hit_RESP     = lookup_hit;
  assign hit_way_RESP = hit_way;
  assign target_RESP  = lookup_hit ? resp_set_q.way[hit_way].target : '0;

  logic [BTB_NUM_WAYS-1:0] up_match;
  logic                    up_way;

  always_comb begin
    up_match = '0;
    for (int w = 0; w < BTB_NUM_WAYS; w++)
      up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
    up_way = lru_q[up_idx];
    if      (up_match[0])          up_way = 1'b0;
    else if (up_match[1])          up_way = 1'b1;
    else if (!valid_q[up_idx][0])  up_way = 1'b0;
    else if (!valid_q[up_idx][1])  up_way = 1'b1;
  end

  // NOTE: the update's LRU write is issued after the lookup's, so on a same-set
  // collision the later non-blocking assignment takes effect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      if (lookup_hit)
        lru_q[resp_idx_q] <= !hit_way;
      if (update_valid) begin
        valid_q[up_idx][up_way] <= 1'b1;
        lru_q[up_idx]           <= !up_way;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (update_valid && !flush) begin
      tag_q[up_idx][up_way]    <= up_tag;
      target_q[up_idx][up_way] <= update_target;
    end
  end

endmodule

// File: tb/tb_btb_tag_lookup.sv
// Directed bench for btb_tag_lookup: an array-of-entries reference model checked
// every cycle, plus literal expectations at each scenario step.
module tb_btb_tag_lookup;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_REQ = 1'b0;
  logic [31:0] PC_REQ = '0;
  logic [8:0]  ASID_REQ = '0;
  logic        valid_RESP, hit_RESP, hit_way_RESP;
  logic [31:0] target_RESP;
  logic        update_valid = 1'b0;
  logic [31:0] update_PC = '0;
  logic [8:0]  update_ASID = '0;
  logic [31:0] update_target = '0;
  logic        flush = 1'b0;

  btb_tag_lookup #(.TARGET_WIDTH(32), .NUM_SETS(256)) dut (
    .CLK(CLK), .RST(RST),
    .valid_REQ(valid_REQ), .PC_REQ(PC_REQ), .ASID_REQ(ASID_REQ),
    .valid_RESP(valid_RESP), .hit_RESP(hit_RESP), .hit_way_RESP(hit_way_RESP),
    .target_RESP(target_RESP),
    .update_valid(update_valid), .update_PC(update_PC), .update_ASID(update_ASID),
    .update_target(update_target), .flush(flush)
  );

  initial forever #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: per-set list of two entries and a replace-next way.
  bit          m_valid [256][2];
  logic [5:0]  m_tag   [256][2];
  logic [31:0] m_tgt   [256][2];
  bit          m_lru   [256];
  bit          pend_touch = 0;
  int          pend_set = 0;
  bit          pend_way = 0;
  logic        e_valid = 0, e_hit = 0, e_way = 0;
  logic [31:0] e_tgt = '0;

  function automatic int set_of(input logic [31:0] pc);
    return int'(pc[11:4]);
  endfunction

  function automatic logic [5:0] tag_of(input logic [31:0] pc, input logic [8:0] asid);
    return pc[23:18] ^ pc[17:12] ^ asid[5:0];
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 256; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_lru[s] = 0;
    end
  endtask

  task automatic model_step();
    int ls, us;
    logic [5:0] lt, ut;
    bit lhit, lway, uway, found;
    logic [31:0] ltgt;
    ls = set_of(PC_REQ);
    lt = tag_of(PC_REQ, ASID_REQ);
    lhit = 0; lway = 0; ltgt = '0;
    if (valid_REQ && !flush)
      for (int w = 1; w >= 0; w--)
        if (m_valid[ls][w] && m_tag[ls][w] == lt) begin
          lhit = 1; lway = w[0]; ltgt = m_tgt[ls][w];
        end
    us = set_of(update_PC);
    ut = tag_of(update_PC, update_ASID);
    found = 0; uway = m_lru[us];
    for (int w = 1; w >= 0; w--)
      if (m_valid[us][w] && m_tag[us][w] == ut) begin found = 1; uway = w[0]; end
    if (!found) begin
      if (!m_valid[us][0]) uway = 0;
      else if (!m_valid[us][1]) uway = 1;
    end
    if (flush) begin
      clear_model();
    end else begin
      if (pend_touch) m_lru[pend_set] = !pend_way;
      if (update_valid) begin
        m_valid[us][uway] = 1;
        m_tag[us][uway]   = ut;
        m_tgt[us][uway]   = update_target;
        m_lru[us]         = !uway;
      end
    end
    e_valid = valid_REQ; e_hit = lhit; e_way = lway; e_tgt = ltgt;
    pend_touch = lhit; pend_set = ls; pend_way = lway;
  endtask

  initial begin
    clear_model();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        clear_model();
        pend_touch = 0;
        e_valid = 0; e_hit = 0; e_way = 0; e_tgt = '0;
      end else begin
        model_step();
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    check("resp_cycle", {29'd0, valid_RESP, hit_RESP, hit_way_RESP, target_RESP},
          {29'd0, e_valid, e_hit, e_way, e_tgt});
  end

  // Each op drives for one cycle, returning 1 time unit into the following cycle.
  task automatic step();
    @(posedge CLK);
    #1;
    valid_REQ = 0; update_valid = 0; flush = 0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [8:0] asid);
    valid_REQ = 1; PC_REQ = pc; ASID_REQ = asid;
    step();
  endtask

  task automatic update(input logic [31:0] pc, input logic [8:0] asid, input logic [31:0] tgt);
    update_valid = 1; update_PC = pc; update_ASID = asid; update_target = tgt;
    step();
  endtask

  task automatic expect_resp(input string name, input bit hit, input bit way, input logic [31:0] tgt);
    check(name, {29'd0, valid_RESP, hit_RESP, hit_way_RESP, target_RESP}, {29'd0, 1'b1, hit, way, tgt});
    check({name, "_model"}, {29'd0, e_valid, e_hit, e_way, e_tgt}, {29'd0, 1'b1, hit, way, tgt});
  endtask

  task automatic pulse_reset();
    RST = 1;
    @(posedge CLK);
    #1;
    RST = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 0;
    check("reset_outputs", {29'd0, valid_RESP, hit_RESP, hit_way_RESP, target_RESP}, 64'd0);

    // Test 1: reset lands while a lookup stream is in flight.
    valid_REQ = 1; PC_REQ = 32'h0000_3010; ASID_REQ = 9'd0;
    @(posedge CLK);
    #2;
    check("t1_pre_reset_valid", {63'd0, valid_RESP}, 64'd1);
    RST = 1;
    #1;
    check("t1_async_reset", {29'd0, valid_RESP, hit_RESP, hit_way_RESP, target_RESP}, 64'd0);
    @(posedge CLK);
    #1;
    RST = 0; valid_REQ = 0;
    lookup(32'h0000_3010, 9'd0);
    expect_resp("t1_empty_miss", 0, 0, 32'd0);

    // Test 2: train then hit.
    update(32'h0000_3010, 9'd0, 32'h0000_8000);
    lookup(32'h0000_3010, 9'd0);
    expect_resp("t2_hit", 1, 0, 32'h0000_8000);

    // Test 3: different PC/ASID folding to the same set and tag.
    lookup(32'h00C3_0010, 9'h003);
    expect_resp("t3_alias", 1, 0, 32'h0000_8000);

    // Ignored PC/ASID bits must not disturb the hash.
    lookup(32'hFF00_3018, 9'h1C0);
    expect_resp("t3_ignored_bits", 1, 0, 32'h0000_8000);

    // Highest set index.
    update(32'h0000_0FF0, 9'd5, 32'h0000_0055);
    lookup(32'h0000_0FF0, 9'd5);
    expect_resp("top_set_hit", 1, 0, 32'h0000_0055);

    pulse_reset();

    // Test 4: allocation and LRU eviction in set 0x01.
    update(32'h0000_0010, 9'd1, 32'h0000_000A);
    update(32'h0000_0010, 9'd2, 32'h0000_000B);
    lookup(32'h0000_0010, 9'd1);
    expect_resp("t4_hit_w0", 1, 0, 32'h0000_000A);
    step();
    update(32'h0000_0010, 9'd3, 32'h0000_000C);
    lookup(32'h0000_0010, 9'd2);
    expect_resp("t4_evicted_miss", 0, 0, 32'd0);
    lookup(32'h0000_0010, 9'd3);
    expect_resp("t4_new_w1", 1, 1, 32'h0000_000C);
    lookup(32'h0000_0010, 9'd1);
    expect_resp("t4_kept_w0", 1, 0, 32'h0000_000A);

    // Test 6: flush with a concurrent lookup and update.
    valid_REQ = 1; PC_REQ = 32'h0000_0010; ASID_REQ = 9'd3;
    update_valid = 1; update_PC = 32'h0000_0010; update_ASID = 9'd4; update_target = 32'h0000_000D;
    flush = 1;
    step();
    expect_resp("t6_flush_masked", 0, 0, 32'd0);
    lookup(32'h0000_0010, 9'd1);
    expect_resp("t6_asid1_miss", 0, 0, 32'd0);
    lookup(32'h0000_0010, 9'd3);
    expect_resp("t6_asid3_miss", 0, 0, 32'd0);
    lookup(32'h0000_0010, 9'd4);
    expect_resp("t6_asid4_miss", 0, 0, 32'd0);

    // Test 5: read-first on a same-cycle update and lookup of an empty set.
    valid_REQ = 1; PC_REQ = 32'h0000_3010; ASID_REQ = 9'd0;
    update_valid = 1; update_PC = 32'h0000_3010; update_ASID = 9'd0; update_target = 32'h0000_1234;
    step();
    expect_resp("t5_read_first_miss", 0, 0, 32'd0);
    lookup(32'h0000_3010, 9'd0);
    expect_resp("t5_next_hit", 1, 0, 32'h0000_1234);

    repeat (3) step();
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btb_tag_lookup.md
Name: btb_tag_lookup

Overview:
- Consumer side of the BTB tag hash: accepts fetch lookups (PC, ASID), compares the hashed tag against a 2-way set-associative BTB array, and returns hit/way/target one cycle later.
- Also accepts training updates from branch resolution, which allocate or overwrite entries using the same hash.
- Sits between the fetch PC generator and the predictor mux in the front end.

Parameters:
- TARGET_WIDTH, 32, width of stored branch target.
- NUM_SETS, 256, number of sets; must equal 2^BTB_SET_INDEX_WIDTH (8).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset; asynchronous, active-high.
- valid_REQ  input  1  lookup request this cycle.
- PC_REQ  input  32  lookup PC.
- ASID_REQ  input  9  lookup ASID.
- valid_RESP  output  1  response valid; 1 cycle after valid_REQ.
- hit_RESP  output  1  tag match on a valid way.
- hit_way_RESP  output  1  matching way; 0 on miss.
- target_RESP  output  TARGET_WIDTH  target of hit way; 0 on miss.
- update_valid  input  1  training write this cycle.
- update_PC  input  32  branch PC.
- update_ASID  input  9  branch ASID.
- update_target  input  TARGET_WIDTH  resolved target.
- flush  input  1  invalidate entire BTB.

Behaviour:
- Field map: set index = PC[11:4], tag = PC[23:18] ^ PC[17:12] ^ ASID[5:0] (BTB_TAG_WIDTH = 6). PC[31:24], PC[3:0] and ASID[8:6] are ignored.
- State per set: 2 x {valid, tag[5:0], target}, plus 1 LRU bit (LRU = way to replace next).
- Reset (RST high, asynchronous):
  - All valid bits 0, all LRU bits 0.
  - Outputs: valid_RESP=0, hit_RESP=0, hit_way_RESP=0, target_RESP=0.
- Lookup pipeline, fixed latency 1:
  - REQ cycle: register the set contents, the computed tag, valid_REQ, and flush.
  - RESP cycle: compare tag against both ways. hit = (valid & tag match) on either way; if both match, way 0 wins.
  - When valid_RESP=0, hit_RESP, hit_way_RESP and target_RESP are 0.
- Read-first: a lookup samples the array as it was before any update or flush written at the same edge.
- Flush masking: a lookup issued in a flush cycle returns valid_RESP=1, hit_RESP=0.
- LRU on lookup hit: in the RESP cycle, LRU[set] <= ~hit_way.
- Update, written at the end of the update_valid cycle:
  - If the tag matches a valid way in the set: overwrite that way's target; LRU <= ~way.
  - Else allocate the victim way: way 0 if invalid, else way 1 if invalid, else LRU way. Write valid=1, tag, target; LRU <= ~victim.
- Same-set conflict: a RESP-stage LRU write and an update to the same set in the same cycle → update's LRU write wins.
- Priority: flush > update > lookup-LRU. Flush clears all valid and LRU bits in one cycle; an update in the flush cycle is dropped.
- Aliasing is accepted: different PC/ASID pairs with equal set and tag hit each other.
- Back-to-back lookups every cycle are supported; no stall and no backpressure.

Decomposition:
- core_types_pkg holds:
  - BTB_TAG_WIDTH = 6, BTB_SET_INDEX_WIDTH = 8, BTB_NUM_WAYS = 2.
  - typedef btb_entry_t {valid, tag, target}.
  - typedef btb_set_t {btb_entry_t way[2], lru}.
- Instantiate btb_tag_hash twice: once for the REQ path, once for the update path. No other sub-module.

Test Plan:
1. Reset then idle: RST=1 mid-stream with valid_REQ=1 → all outputs 0 immediately; after release, lookup of PC=0x0000_3010, ASID=0 → valid_RESP=1, hit_RESP=0.
2. Train then hit: update PC=0x0000_3010, ASID=0, target=0x0000_8000 (set 0x01, tag 0x03); next-cycle lookup of the same PC/ASID → hit_RESP=1, hit_way_RESP=0, target_RESP=0x0000_8000.
3. Alias: after test 2, lookup PC=0x00C3_0010, ASID=0x003 (tag 0x30^0x30^0x03 = 0x03, set 0x01) → hit_RESP=1, target_RESP=0x0000_8000.
4. LRU eviction, all with PC=0x0000_0010 (set 0x01):
   - Update ASID=1 with target 0xA (lands in way 0), then ASID=2 with target 0xB (lands in way 1).
   - Lookup ASID=1 → hit, way 0.
   - Update ASID=3 with target 0xC → replaces way 1.
   - Lookup ASID=2 → miss; ASID=3 → hit, way 1, target 0xC; ASID=1 → hit, target 0xA.
5. Read-first collision: update and lookup of PC=0x0000_3010, ASID=0 in the same cycle on an empty set → response miss; the same lookup repeated next cycle → hit.
6. Flush: with the entries from test 4 present, assert flush together with a lookup of ASID=3 and an update of ASID=4 → lookup returns miss; following lookups of ASID=1, 3 and 4 all miss.
